wishbone_arbiter: RTL
=====================

Name: wishbone_arbiter

Overview:
- Round-robin arbiter that lets NUM_MASTERS Wishbone masters share one Wishbone slave port (e.g. slave_wishbone).
- Sits between the master_wishbone instances and the single slave, and sequences bus ownership per cycle (cyc) tenure.
- Routes the granted master's request signals to the slave and routes the slave's ack/err/data back to that master only.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 5, address width
DATA_WIDTH, 32, data width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 16, watchdog limit; used only when WB_ARB_TIMEOUT_EN is defined

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master we
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k at slice k
m_data_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_cti_i  in  NUM_MASTERS*3  packed cycle-type identifiers
m_tag_add_i  in  NUM_MASTERS  per-master address tag
m_ack_o  out  NUM_MASTERS  ack, routed to the granted master only
m_err_o  out  NUM_MASTERS  err, routed to the granted master only
m_data_o  out  DATA_WIDTH  slave read data, broadcast to all masters
s_cyc_o, s_stb_o, s_we_o  out  1  slave request
s_addr_o  out  ADDR_WIDTH  slave address
s_data_o  out  DATA_WIDTH  slave write data
s_sel_o  out  SEL_WIDTH  slave byte selects
s_cti_o  out  3  slave cycle-type identifier
s_tag_add_o  out  1  slave address tag
s_ack_i, s_err_i  in  1  slave responses
s_data_i  in  DATA_WIDTH  slave read data
grant_o  out  NUM_MASTERS  one-hot grant; all zero when idle
state_out  out  2  FSM state: 0 IDLE, 1 BUSY, 2 RELEASE, 3 TERR

Behaviour:
- Reset (asynchronous): state IDLE, grant_o 0, round-robin pointer 0. All s_* outputs, m_ack_o and m_err_o read 0.
- IDLE:
  - If any m_cyc_i bit is set, grant the first requester at or after the pointer, searching upward with wrap.
  - Register the grant and go to BUSY. Arbitration latency is 1 cycle: s_cyc_o rises the cycle after the request is seen.
- BUSY:
  - s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g]. we, addr, data, sel, cti and tag are muxed combinationally from master g.
  - m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i, with zero added latency. All other m_ack_o and m_err_o bits are 0.
  - Stays in BUSY for the whole cyc tenure, including multi-beat bursts (cti 3'b001/3'b010). The grant is never preempted.
  - When m_cyc_i[g] falls, go to RELEASE and set pointer = (g+1) mod NUM_MASTERS.
- RELEASE:
  - Exactly one cycle. s_cyc_o = s_stb_o = 0, grant_o = 0. Guarantees at least one idle cycle between owners.
  - Then go to IDLE.
- Non-granted masters simply wait; their requests are never acknowledged.
- If s_ack_i or s_err_i arrives while s_stb_o = 0, it is ignored (not routed).
- Simultaneous requests are resolved strictly by the pointer. A master releasing and re-requesting immediately is served last among the current requesters.
- Asserting rst_i mid-transfer drops the grant and all slave outputs immediately. The pointer returns to 0.
- Pointer arithmetic wraps modulo NUM_MASTERS. The one-hot grant and the index are kept consistent.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, a counter increments each cycle that s_stb_o = 1 and s_ack_i = s_err_i = 0. It clears on ack, on err, or when stb is low.
  - When the counter reaches TIMEOUT_CYCLES, pulse m_err_o[g] for 1 cycle, force s_cyc_o = s_stb_o = 0, and enter TERR.
  - TERR holds the slave outputs low until m_cyc_i[g] falls, then goes to RELEASE with the pointer advanced.
- Undefined: no counter and no TERR state. A hung slave holds the grant indefinitely.

Test Plan:
- Single master: master 1 writes 0xDEADBEEF to addr 0x04 -> s_cyc_o rises 1 cycle after m_cyc_i[1]; grant_o = 4'b0010; m_ack_o[1] follows s_ack_i; state sequence 0,1,2,0.
- Simultaneous requests: all 4 masters request from reset, each doing single reads -> grants in order 0,1,2,3, each separated by one RELEASE cycle.
- Burst hold: master 2 runs a 4-beat incrementing burst (cti 010, 010, 010, 111) while master 0 requests -> master 0 is granted only after m_cyc_i[2] falls; no beat of master 2 is interleaved.
- Response isolation: master 3 granted, slave returns err -> only m_err_o[3] = 1; m_ack_o = 0; other err bits 0.
- Reset mid-burst: rst_i asserted on beat 2 -> s_cyc_o and grant_o go 0 without waiting for a clock edge; after release, master 0 has priority.
- Timeout (WB_ARB_TIMEOUT_EN): slave never acks -> m_err_o[g] pulses exactly 16 cycles after stb rises; state = 3 until cyc drops, then 2, then 0.

Source files
------------

// File: rtl/wishbone_arbiter_if.sv
// Bundles the per-master Wishbone request/response lines and the shared slave port.
interface wishbone_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8
);
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [NUM_MASTERS*3-1:0]          m_cti_i;
  logic [NUM_MASTERS-1:0]            m_tag_add_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [DATA_WIDTH-1:0]             m_data_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_addr_o;
  logic [DATA_WIDTH-1:0]             s_data_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [2:0]                        s_cti_o;
  logic                              s_tag_add_o;
  logic                              s_ack_i;
  logic                              s_err_i;
  logic [DATA_WIDTH-1:0]             s_data_i;

  // The arbiter occupies the slave seat of the masters' bus and forwards to the real slave.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i, m_cti_i, m_tag_add_i,
    input  s_ack_i, s_err_i, s_data_i,
    output m_ack_o, m_err_o, m_data_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o, s_cti_o, s_tag_add_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i, m_cti_i, m_tag_add_i,
    output s_ack_i, s_err_i, s_data_i,
    input  m_ack_o, m_err_o, m_data_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o, s_cti_o, s_tag_add_o
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters, one owner per cyc tenure.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wishbone_arbiter_if.slave      bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [1:0]             state_out
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wishbone_arbiter: unsupported parameter combination");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2, TERR = 2'd3} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;
`endif

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]        idx_q, idx_d, ptr_q, ptr_d;
  logic [IDX_W-1:0]        pick_s, cand_s;
  logic                    found_s, route_s, tout_s;
  logic                    owner_cyc_s, owner_stb_s, owner_we_s, owner_tag_s;
  logic [ADDR_WIDTH-1:0]   owner_addr_s;
  logic [DATA_WIDTH-1:0]   owner_data_s;
  logic [SEL_WIDTH-1:0]    owner_sel_s;
  logic [2:0]              owner_cti_s;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return sum[IDX_W-1:0];
  endfunction

  assign owner_cyc_s = |(bus.m_cyc_i & grant_q);
  assign owner_stb_s = |(bus.m_stb_i & grant_q);
  assign owner_we_s  = |(bus.m_we_i & grant_q);
  assign owner_tag_s = |(bus.m_tag_add_i & grant_q);

  // First requester at or after the pointer, searching upward with wrap.
  always_comb begin
    pick_s  = ptr_q;
    cand_s  = ptr_q;
    found_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s = rr_next(ptr_q, i);
      if (!found_s && bus.m_cyc_i[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot OR-mux of the owner's request fields.
  always_comb begin
    owner_addr_s = '0;
    owner_data_s = '0;
    owner_sel_s  = '0;
    owner_cti_s  = 3'b000;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      owner_addr_s = owner_addr_s | ({ADDR_WIDTH{grant_q[k]}} & bus.m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
      owner_data_s = owner_data_s | ({DATA_WIDTH{grant_q[k]}} & bus.m_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      owner_sel_s  = owner_sel_s  | ({SEL_WIDTH{grant_q[k]}}  & bus.m_sel_i[k*SEL_WIDTH +: SEL_WIDTH]);
      owner_cti_s  = owner_cti_s  | ({3{grant_q[k]}}          & bus.m_cti_i[k*3 +: 3]);
    end
  end

  // Next-state logic; route_s opens the owner <-> slave path only while BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    route_s = 1'b0;
    tout_s  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_s;
          idx_d   = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        route_s = 1'b1;
        if (!owner_cyc_s) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = rr_next(idx_q, 1);
`ifdef WB_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          route_s = 1'b0;
          tout_s  = 1'b1;
          state_d = TERR;
        end else if (owner_stb_s && !bus.s_ack_i && !bus.s_err_i) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end else begin
          state_d = BUSY;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
`ifdef WB_ARB_TIMEOUT_EN
      TERR: begin
        if (!owner_cyc_s) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = rr_next(idx_q, 1);
        end else begin
          state_d = TERR;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slave-side request and master-side response routing.
  always_comb begin
    bus.s_cyc_o     = route_s & owner_cyc_s;
    bus.s_stb_o     = route_s & owner_stb_s;
    bus.s_we_o      = route_s & owner_we_s;
    bus.s_tag_add_o = route_s & owner_tag_s;
    bus.s_addr_o    = route_s ? owner_addr_s : '0;
    bus.s_data_o    = route_s ? owner_data_s : '0;
    bus.s_sel_o     = route_s ? owner_sel_s  : '0;
    bus.s_cti_o     = route_s ? owner_cti_s  : 3'b000;
    bus.m_ack_o     = (route_s && owner_stb_s && bus.s_ack_i) ? grant_q : '0;
    bus.m_err_o     = (tout_s || (route_s && owner_stb_s && bus.s_err_i)) ? grant_q : '0;
    bus.m_data_o    = bus.s_data_i;
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_o   = grant_q;
  assign state_out = state_q;
endmodule
